pc_gen: RTL and testbench

//   Parametrised program-counter generator at the head of the fetch stage.

---
 rtl/pc_gen.sv | 108 ++++++++++
 tb/tb_pc_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator at the head of fetch: boot delay, then a valid/ready PC stream
// with stall, branch/trap redirect, halt/resume and misaligned-target trapping.
module pc_gen #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              INC         = 4,
    parameter int              ALIGN_BITS  = 2,
    parameter int              BOOT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ena_o,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_i,
    output logic            misalign_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int              CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = (BOOT_CYCLES > 0) ? CNT_W'(BOOT_CYCLES - 1) : '0;
    localparam logic [XLEN-1:0] INC_V     = XLEN'(INC);

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   pc_reg, pc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              misalign_reg, misalign_next;
    logic              target_misaligned;

    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign target_misaligned = |redirect_pc_i[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign target_misaligned = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_VEC;
            cnt_reg      <= '0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            cnt_reg      <= cnt_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        cnt_next      = cnt_reg;
        misalign_next = 1'b0;
        case (state_reg)
            BOOT: begin
                if (BOOT_CYCLES == 0 || cnt_reg == BOOT_LAST) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RUN, HALT: begin
                // Flush sources override handshake, stall and halt alike.
                if (trap_i) begin
                    pc_next = trap_vec_i;
                end else if (redirect_i) begin
                    if (target_misaligned) begin
                        pc_next       = trap_vec_i;
                        misalign_next = 1'b1;
                    end else begin
                        pc_next = redirect_pc_i;
                    end
                end else if (state_reg == RUN && !halt_i && pc_ready_i && !stall_i) begin
                    pc_next = pc_reg + INC_V;
                end

                if (state_reg == RUN) begin
                    if (halt_i && !trap_i && !redirect_i) state_next = HALT;
                end else if (!halt_i) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    assign pc_o       = pc_reg;
    assign pc_valid_o = (state_reg == RUN);
    assign ena_o      = (state_reg != BOOT);
    assign misalign_o = misalign_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus randomized traffic against a cycle model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_ready = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap = 1'b0;
    logic [31:0] trap_vec = '0;
    logic        halt = 1'b0;

    logic        ena_a, valid_a, mis_a;
    logic [31:0] pc_a;
    logic [1:0]  state_a;
    logic        ena_b, valid_b, mis_b;
    logic [31:0] pc_b;
    logic [1:0]  state_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of DUT A: mode 0=boot 1=run 2=halt
    int          m_mode;
    int          m_boot;
    logic [31:0] m_pc;
    logic        m_mis;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .INC(4), .ALIGN_BITS(2), .BOOT_CYCLES(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena_o(ena_a), .pc_o(pc_a), .pc_valid_o(valid_a),
        .pc_ready_i(pc_ready), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .trap_i(trap), .trap_vec_i(trap_vec), .halt_i(halt), .misalign_o(mis_a), .state_o(state_a)
    );

    pc_gen #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .INC(4), .ALIGN_BITS(2), .BOOT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena_o(ena_b), .pc_o(pc_b), .pc_valid_o(valid_b),
        .pc_ready_i(pc_ready), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .trap_i(trap), .trap_vec_i(trap_vec), .halt_i(halt), .misalign_o(mis_b), .state_o(state_b)
    );

    task automatic model_reset();
        m_mode = 0;
        m_boot = 0;
        m_pc   = 32'h0;
        m_mis  = 1'b0;
    endtask

    task automatic model_step();
        bit bad_target;
        bit in_run;
        bad_target = (redirect_pc % 4) != 0;
        in_run     = (m_mode == 1);
        m_mis      = 1'b0;
        if (m_mode == 0) begin
            if (m_boot + 1 >= 3) m_mode = 1;
            else m_boot = m_boot + 1;
        end else begin
            if (trap) m_pc = trap_vec;
            else if (redirect && bad_target) begin
                m_pc  = trap_vec;
                m_mis = 1'b1;
            end else if (redirect) m_pc = redirect_pc;
            else if (in_run && !halt && pc_ready && !stall) m_pc = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
            if (in_run && halt && !trap && !redirect) m_mode = 2;
            else if (!in_run && !halt) m_mode = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic clear_inputs();
        pc_ready = 1'b0; stall = 1'b0; redirect = 1'b0; trap = 1'b0; halt = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        tick(); tick();
        n_cmp++; if (pc_a !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_a, 32'h0); end
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        n_cmp++; if (ena_a !== 1'b0) begin n_err++; $display("FAIL reset_ena: got %b want 0", ena_a); end
        n_cmp++; if (state_a !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_a); end
        n_cmp++; if (mis_a !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %b want 0", mis_a); end
        $display("reset: pc=%h valid=%b ena=%b state=%0d", pc_a, valid_a, ena_a, state_a);
    endtask

    task automatic test_boot();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL boot_valid[%0d]: got %b want 0", i, valid_a); end
            tick();
        end
        n_cmp++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL boot_done_valid: got %b want 1", valid_a); end
        n_cmp++; if (ena_a !== 1'b1) begin n_err++; $display("FAIL boot_done_ena: got %b want 1", ena_a); end
        n_cmp++; if (pc_a !== 32'h0) begin n_err++; $display("FAIL boot_done_pc: got %h want 0", pc_a); end
        $display("boot: entered RUN pc=%h", pc_a);
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        pc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            want = 32'(4 * i);
            n_cmp++; if (pc_a !== want) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_a, want); end
            $display("seq: pc=%h accepted", pc_a);
            tick();
        end
        pc_ready = 1'b0;
        tick();
        n_cmp++; if (pc_a !== 32'h10) begin n_err++; $display("FAIL hold_not_ready: got %h want 10", pc_a); end
        pc_ready = 1'b1; stall = 1'b1;
        tick();
        n_cmp++; if (pc_a !== 32'h10) begin n_err++; $display("FAIL hold_stall: got %h want 10", pc_a); end
        $display("seq: held at pc=%h", pc_a);
        clear_inputs();
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        n_cmp++; if (pc_a !== 32'h100) begin n_err++; $display("FAIL redirect_pc: got %h want 100", pc_a); end
        trap = 1'b1; trap_vec = 32'h80; redirect_pc = 32'h100;
        tick();
        n_cmp++; if (pc_a !== 32'h80) begin n_err++; $display("FAIL trap_over_redirect: got %h want 80", pc_a); end
        $display("redirect: pc=%h after trap", pc_a);
        clear_inputs();
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 32'h102; trap_vec = 32'h200;
        tick();
        n_cmp++; if (pc_a !== 32'h200) begin n_err++; $display("FAIL misalign_pc: got %h want 200", pc_a); end
        n_cmp++; if (mis_a !== 1'b1) begin n_err++; $display("FAIL misalign_pulse: got %b want 1", mis_a); end
        clear_inputs();
        tick();
        n_cmp++; if (mis_a !== 1'b0) begin n_err++; $display("FAIL misalign_one_cycle: got %b want 0", mis_a); end
        trap = 1'b1; redirect = 1'b1; redirect_pc = 32'h102; trap_vec = 32'h300;
        tick();
        n_cmp++; if (pc_a !== 32'h300) begin n_err++; $display("FAIL trap_misalign_pc: got %h want 300", pc_a); end
        n_cmp++; if (mis_a !== 1'b0) begin n_err++; $display("FAIL trap_misalign_nopulse: got %b want 0", mis_a); end
        $display("misalign: pc=%h mis=%b", pc_a, mis_a);
        clear_inputs();
    endtask

    task automatic test_halt();
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0; halt = 1'b1; pc_ready = 1'b1;
        tick();
        n_cmp++; if (state_a !== 2'd2) begin n_err++; $display("FAIL halt_state: got %0d want 2", state_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL halt_valid: got %b want 0", valid_a); end
        n_cmp++; if (pc_a !== 32'h20) begin n_err++; $display("FAIL halt_pc: got %h want 20", pc_a); end
        n_cmp++; if (ena_a !== 1'b1) begin n_err++; $display("FAIL halt_ena: got %b want 1", ena_a); end
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        n_cmp++; if (pc_a !== 32'h40) begin n_err++; $display("FAIL halt_redirect_pc: got %h want 40", pc_a); end
        n_cmp++; if (state_a !== 2'd2) begin n_err++; $display("FAIL halt_redirect_state: got %0d want 2", state_a); end
        redirect = 1'b0; halt = 1'b0;
        tick();
        n_cmp++; if (state_a !== 2'd1) begin n_err++; $display("FAIL resume_state: got %0d want 1", state_a); end
        n_cmp++; if (pc_a !== 32'h40) begin n_err++; $display("FAIL resume_pc: got %h want 40", pc_a); end
        $display("halt: resumed state=%0d pc=%h", state_a, pc_a);
        clear_inputs();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            pc_ready    = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            trap        = ($urandom_range(0, 15) == 0);
            redirect_pc = {$urandom_range(0, 32'h3FFF), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            trap_vec    = {$urandom_range(0, 32'h3FFF), 2'b00};
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            tick();
            n_cmp++; if (pc_a !== m_pc) begin n_err++; bad++; $display("FAIL rand_pc[%0d]: got %h want %h", i, pc_a, m_pc); end
            n_cmp++; if (state_a !== 2'(m_mode)) begin n_err++; bad++; $display("FAIL rand_state[%0d]: got %0d want %0d", i, state_a, m_mode); end
            n_cmp++; if (valid_a !== (m_mode == 1)) begin n_err++; bad++; $display("FAIL rand_valid[%0d]: got %b want %b", i, valid_a, m_mode == 1); end
            n_cmp++; if (ena_a !== (m_mode != 0)) begin n_err++; bad++; $display("FAIL rand_ena[%0d]: got %b want %b", i, ena_a, m_mode != 0); end
            n_cmp++; if (mis_a !== m_mis) begin n_err++; bad++; $display("FAIL rand_mis[%0d]: got %b want %b", i, mis_a, m_mis); end
        end
        $display("random: 400 cycles, %0d discrepancies", bad);
        clear_inputs();
    endtask

    task automatic test_wrap_and_async_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pc_a !== 32'h0) begin n_err++; $display("FAIL async_reset_pc_a: got %h want 0", pc_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL async_reset_valid_a: got %b want 0", valid_a); end
        model_reset();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (state_b !== 2'd1) begin n_err++; $display("FAIL noboot_state: got %0d want 1", state_b); end
        n_cmp++; if (pc_b !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL noboot_pc: got %h want fffffffc", pc_b); end
        pc_ready = 1'b1;
        tick();
        n_cmp++; if (pc_b !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 0", pc_b); end
        n_cmp++; if (mis_b !== 1'b0) begin n_err++; $display("FAIL wrap_flag: got %b want 0", mis_b); end
        $display("wrap: pc=%h", pc_b);
        tick(); tick();
        n_cmp++; if (state_a !== 2'(m_mode)) begin n_err++; $display("FAIL prereset_state_a: got %0d want %0d", state_a, m_mode); end
        n_cmp++; if (pc_a !== m_pc) begin n_err++; $display("FAIL prereset_pc_a: got %h want %h", pc_a, m_pc); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pc_b !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL midrun_reset_pc_b: got %h want fffffffc", pc_b); end
        n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL midrun_reset_valid_b: got %b want 0", valid_b); end
        n_cmp++; if (pc_a !== 32'h0) begin n_err++; $display("FAIL midrun_reset_pc_a: got %h want 0", pc_a); end
        n_cmp++; if (state_a !== 2'd0) begin n_err++; $display("FAIL midrun_reset_state_a: got %0d want 0", state_a); end
        n_cmp++; if (ena_a !== 1'b0) begin n_err++; $display("FAIL midrun_reset_ena_a: got %b want 0", ena_a); end
        $display("async reset: pc_a=%h pc_b=%h", pc_a, pc_b);
        model_reset();
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_boot();
        test_sequential();
        test_redirect();
        test_misalign();
        test_halt();
        test_random();
        test_wrap_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
